// File: rtl/jstepper.sv
// Multi-phase instruction stepper: one-hot step outputs with nested enable/set phases.
// Optional freeze at step boundaries is compiled in with `define JSTEPPER_HALT_EN.
module jstepper #(
    parameter int NSTEPS = 6
) (
    input  logic              wclk,
    input  logic              wrstn,
    input  logic              whalt,
    input  logic              wrestart,
    output logic [NSTEPS-1:0] ws,
    output logic              wclke,
    output logic              wclks,
    output logic              wwrap
);

    localparam int STW = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [1:0]     PH_SET  = 2'd1;
    localparam logic [1:0]     PH_REST = 2'd3;
    localparam logic [STW-1:0] ST_LAST = STW'(NSTEPS - 1);

    logic [1:0]     ph_q, ph_d;
    logic [STW-1:0] st_q, st_d;
    logic           run_q, run_d;
    logic           pend_q, pend_d;
    logic           wrap_q, wrap_d;
    logic           halt_req;
    logic           restart_take;

`ifdef JSTEPPER_HALT_EN
    assign halt_req = whalt;
`else
    logic unused_whalt;
    assign unused_whalt = whalt;
    assign halt_req     = 1'b0;
`endif

    // A restart requested on the boundary cycle itself is honoured at that boundary.
    assign restart_take = pend_q | wrestart;

    always_comb begin
        ph_d   = ph_q;
        st_d   = st_q;
        run_d  = run_q;
        pend_d = pend_q | wrestart;
        wrap_d = 1'b0;
        if (ph_q != PH_REST) begin
            ph_d = ph_q + 2'd1;
        end else if (!halt_req) begin
            ph_d   = 2'd0;
            run_d  = 1'b1;
            pend_d = 1'b0;
            if (restart_take || st_q == ST_LAST) begin
                st_d   = '0;
                wrap_d = run_q;
            end else begin
                st_d = st_q + 1'b1;
            end
        end
    end

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            ph_q   <= PH_REST;
            st_q   <= ST_LAST;
            run_q  <= 1'b0;
            pend_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            st_q   <= st_d;
            run_q  <= run_d;
            pend_q <= pend_d;
            wrap_q <= wrap_d;
        end
    end

    // Outputs decode straight from registers so an asserted reset clears them at once.
    assign ws    = run_q ? (NSTEPS'(1) << st_q) : '0;
    assign wclke = run_q && (ph_q != PH_REST);
    assign wclks = run_q && (ph_q == PH_SET);
    assign wwrap = wrap_q;

endmodule

// File: tb/tb_jstepper.sv
// Self-checking bench for jstepper: directed walkthroughs plus randomized run
// against a step/phase reference model.
module tb_jstepper;

    localparam int N = 6;

    logic         wclk = 1'b0;
    logic         wrstn = 1'b0;
    logic         whalt = 1'b0;
    logic         wrestart = 1'b0;
    logic [N-1:0] ws;
    logic         wclke, wclks, wwrap;

    int checks = 0;
    int failures = 0;

    // Reference model: step number 1..N (0 = not yet running), phase 0..3.
    int m_step, m_phase;
    bit m_pend, m_wrap;

`ifdef JSTEPPER_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    jstepper #(.NSTEPS(N)) dut (
        .wclk     (wclk),
        .wrstn    (wrstn),
        .whalt    (whalt),
        .wrestart (wrestart),
        .ws       (ws),
        .wclke    (wclke),
        .wclks    (wclks),
        .wwrap    (wwrap)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_step = 0; m_phase = 3; m_pend = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit h, input bit r);
        int nxt;
        if (m_phase < 3) begin
            m_phase++;
            m_pend |= r;
            m_wrap = 0;
        end else if (HALT_EN && h) begin
            m_pend |= r;
            m_wrap = 0;
        end else begin
            if (m_pend || r || m_step == 0) nxt = 1;
            else nxt = (m_step % N) + 1;
            m_wrap  = (m_step != 0) && (nxt == 1);
            m_step  = nxt;
            m_phase = 0;
            m_pend  = 0;
        end
    endtask

    task automatic compare_model();
        int exp_ws;
        exp_ws = (m_step == 0) ? 0 : (1 << (m_step - 1));
        chk("ws", int'(ws), exp_ws);
        chk("wclke", int'(wclke), int'(m_step != 0 && m_phase != 3));
        chk("wclks", int'(wclks), int'(m_step != 0 && m_phase == 1));
        chk("wwrap", int'(wwrap), int'(m_wrap));
    endtask

    task automatic tick(input bit h, input bit r);
        whalt = h;
        wrestart = r;
        @(posedge wclk);
        model_step(h, r);
        #1;
        compare_model();
    endtask

    // Assert reset between edges, check outputs drop before any clock, release later.
    task automatic async_reset();
        #2 wrstn = 1'b0;
        #1;
        model_reset();
        chk("rst_ws", int'(ws), 0);
        chk("rst_wclke", int'(wclke), 0);
        chk("rst_wclks", int'(wclks), 0);
        chk("rst_wwrap", int'(wwrap), 0);
        @(posedge wclk);
        #1;
        compare_model();
        #2 wrstn = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        chk("reset_ws", int'(ws), 0);
        chk("reset_wclke", int'(wclke), 0);
        chk("reset_wclks", int'(wclks), 0);
        chk("reset_wwrap", int'(wwrap), 0);
        @(posedge wclk);
        #3 wrstn = 1'b1;

        // 24 clocks: each step for 4 clocks, enable 1,1,1,0 and set 0,1,0,0.
        for (int k = 1; k <= 24; k++) begin
            tick(1'b0, 1'b0);
            chk("seq_ws", int'(ws), 1 << ((k - 1) / 4));
            chk("seq_wclke", int'(wclke), int'(((k - 1) % 4) != 3));
            chk("seq_wclks", int'(wclks), int'(((k - 1) % 4) == 1));
            chk("seq_wwrap", int'(wwrap), 0);
        end
        tick(1'b0, 1'b0);
        chk("wrap_ws", int'(ws), 1);
        chk("wrap_pulse", int'(wwrap), 1);
        tick(1'b0, 1'b0);
        chk("wrap_single", int'(wwrap), 0);

        // Now at step 1 ph1; advance to step 3 ph1, then pulse restart.
        for (int k = 0; k < 8; k++) tick(1'b0, 1'b0);
        chk("pre_restart_ws", int'(ws), 4);
        tick(1'b0, 1'b1);
        chk("restart_ph2_ws", int'(ws), 4);
        tick(1'b0, 1'b0);
        chk("restart_ph3_ws", int'(ws), 4);
        chk("restart_ph3_wclke", int'(wclke), 0);
        tick(1'b0, 1'b0);
        chk("restart_ws", int'(ws), 1);
        chk("restart_wrap", int'(wwrap), 1);

        // Step 1 ph0 -> step 5 ph1 is 17 clocks; then reset mid-step.
        for (int k = 0; k < 17; k++) tick(1'b0, 1'b0);
        chk("pre_reset_ws", int'(ws), 16);
        chk("pre_reset_wclks", int'(wclks), 1);
        async_reset();
        tick(1'b0, 1'b0);
        chk("post_reset_ws", int'(ws), 1);
        chk("post_reset_wclke", int'(wclke), 1);
        chk("post_reset_wwrap", int'(wwrap), 0);

`ifdef JSTEPPER_HALT_EN
        // At step 1 ph0; reach step 2 ph2 (6 clocks), then hold halt for 10 clocks.
        for (int k = 0; k < 6; k++) tick(1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0);
            chk("halt_ws", int'(ws), 2);
            if (k > 0) chk("halt_wclke", int'(wclke), 0);
        end
        tick(1'b0, 1'b0);
        chk("resume_ws", int'(ws), 4);
        chk("resume_wclke", int'(wclke), 1);
        // Step 3 ph0 -> step 4 ph3 is 7 clocks; halt+restart together for 3 clocks.
        for (int k = 0; k < 7; k++) tick(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b1);
            chk("halt_rst_ws", int'(ws), 8);
        end
        tick(1'b0, 1'b0);
        chk("halt_rst_resume_ws", int'(ws), 1);
        chk("halt_rst_resume_wrap", int'(wwrap), 1);
`endif

        // Randomized run against the model, with occasional asynchronous resets.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(99) == 0) async_reset();
            else tick($urandom_range(3) == 0, $urandom_range(7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jstepper.md
JSTEPPER -- requirements
Module: jstepper

Interface
REQ-001 The module SHALL have parameter NSTEPS, default 6, which sets the number of steps per instruction cycle (legal range 2..8).
REQ-002 The module SHALL have port wclk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The module SHALL have port wrstn, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-004 The module SHALL have port whalt, input, 1 bit: the request to freeze at the next step boundary.
REQ-005 The module SHALL have port wrestart, input, 1 bit: the request to jump to step 1 at the next step boundary.
REQ-006 The module SHALL have port ws, output, NSTEPS bits: the one-hot current step; ws[0] is step 1.
REQ-007 The module SHALL have port wclke, output, 1 bit: the enable phase, for bus drive into gate-level register enables.
REQ-008 The module SHALL have port wclks, output, 1 bit: the set phase, for latch strobe into gate-level memory bits.
REQ-009 The module SHALL have port wwrap, output, 1 bit: a one-cycle pulse on entry to step 1 from a prior step.

Function
REQ-010 State SHALL be a 2-bit phase counter ph (0..3), a step index st (0..NSTEPS-1), a run flag, a sticky restart flag, and a registered wwrap.
REQ-011 Phase decode SHALL be: ph0 gives wclke=1, wclks=0; ph1 gives wclke=1, wclks=1; ph2 gives wclke=1, wclks=0; ph3 (rest) gives wclke=0, wclks=0.
REQ-012 Consequently wclks SHALL always be nested strictly inside wclke, with one rest cycle between steps.
REQ-013 ws SHALL equal one-hot(st) when run=1, and all-zero when run=0.
REQ-014 wclke and wclks SHALL be 0 whenever run=0.
REQ-015 Within a step, ph SHALL increment 0 to 1 to 2 to 3, one per clock.
REQ-016 At ph3 with no halt, the next state SHALL be ph0 and st=(restart_pending ? 0 : st+1 mod NSTEPS), and run SHALL be set to 1.
REQ-017 wrestart SHALL be sampled every cycle and OR-ed into restart_pending, which SHALL clear when consumed at a ph3 boundary.
REQ-018 A restart SHALL never truncate the current step mid-phase.
REQ-019 wwrap SHALL be 1 for exactly the one cycle in which st=0 and ph=0 were entered from st=NSTEPS-1 or by restart.
REQ-020 wwrap SHALL stay 0 on the first step-1 entry after reset.
REQ-021 Step sequence SHALL be 1 to NSTEPS to 1, with no skipped or duplicated step except by restart.
REQ-022 Simultaneous whalt and wrestart at ph3: halt SHALL win for that boundary, and the restart SHALL remain pending and be taken on resume.
REQ-023 Startup latency SHALL be one clock: the first rising edge after reset release gives ws=1, ph0, and wclke=1.

Reset
REQ-024 While wrstn=0, state SHALL be ph=3, st=NSTEPS-1, run=0, restart_pending=0, wwrap=0.
REQ-025 While wrstn=0, outputs SHALL be ws=0, wclke=0, wclks=0, wwrap=0, independent of wclk.
REQ-026 Reset asserted mid-step SHALL drop wclke and wclks immediately (asynchronously) and discard any pending restart.

Configuration
REQ-027 With macro JSTEPPER_HALT_EN defined, whalt sampled 1 at ph3 SHALL hold ph=3, st, and run unchanged (wclke=wclks=0, ws holds the current step) until whalt is sampled 0.
REQ-028 With JSTEPPER_HALT_EN defined, whalt at ph0..ph2 SHALL have no effect until the step completes.
REQ-029 Without JSTEPPER_HALT_EN, the whalt port SHALL still exist but be ignored, and the stepper SHALL free-run.

Verification
REQ-030 With NSTEPS=6, release reset and run 24 clocks: ws SHALL read 000001 through 100000, each for 4 clocks; wclke SHALL follow 1,1,1,0 and wclks 0,1,0,0 per step; wwrap SHALL stay 0.
REQ-031 Continue to clock 25: ws SHALL be 000001 and wwrap=1 for exactly one cycle.
REQ-032 Pulse wrestart for one cycle during step 3 ph1: step 3 SHALL complete all 4 phases, then ws SHALL be 000001 with wwrap=1.
REQ-033 With JSTEPPER_HALT_EN, hold whalt=1 from step 2 ph2 for 10 clocks: step 2 SHALL finish, then ws=000010 with wclke=wclks=0 throughout the hold; after release, step 3 ph0 SHALL follow.
REQ-034 With JSTEPPER_HALT_EN, assert whalt and wrestart together at step 4 ph3 for 3 clocks, then drop both: ws SHALL hold 001000, then become 000001 with wwrap=1.
REQ-035 Assert wrstn=0 asynchronously at step 5 ph1: ws, wclke, wclks SHALL go to 0 before the next clock edge; after release, step 1 ph0 SHALL follow one edge later.
